// File: rtl/ecc_scrub_ctrl_pkg.sv
// Shared types and helpers for the ECC scrub controller: FSM state encoding,
// the syndrome values that point at a data bit, and the Hamming(7,4) syndrome.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CHECK,
        CORRECT,
        WAIT
    } scrub_state_t;

    // Syndrome {s2,s1,s0} that identifies a flipped data bit.
    // 001/010/100 point at a parity bit and need no data repair.
    localparam logic [2:0] SYN_D3 = 3'b011;
    localparam logic [2:0] SYN_D2 = 3'b101;
    localparam logic [2:0] SYN_D1 = 3'b110;
    localparam logic [2:0] SYN_D0 = 3'b111;

    // Recompute one block's syndrome from stored parity p and live data d.
    function automatic logic [2:0] hamming_syndrome(input logic [2:0] p, input logic [3:0] d);
        hamming_syndrome = {p[2] ^ d[2] ^ d[1] ^ d[0],
                            p[1] ^ d[3] ^ d[1] ^ d[0],
                            p[0] ^ d[3] ^ d[2] ^ d[0]};
    endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// Corrected-word handshake from the scrubber back to the counter stage.
interface ecc_scrub_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             corr_valid;
    logic [WIDTH-1:0] corr_data;
    logic             corr_ready;

    modport master (output corr_valid, output corr_data, input corr_ready);
    modport slave  (input corr_valid, input corr_data, output corr_ready);
endinterface

// File: rtl/ecc_scrub_ctrl_block_fix.sv
// Single Hamming(7,4) block repair: flips the data bit named by the syndrome.
module ecc_block_fix
    import ecc_scrub_pkg::*;
(
    input  logic [2:0] syn_i,
    input  logic [3:0] data_i,
    output logic [3:0] fixed_o,
    output logic       data_err_o
);

    // Decode the syndrome into a single data-bit flip; parity-only syndromes pass through.
    always_comb begin
        fixed_o    = data_i;
        data_err_o = 1'b0;
        case (syn_i)
            SYN_D3: begin fixed_o[3] = ~data_i[3]; data_err_o = 1'b1; end
            SYN_D2: begin fixed_o[2] = ~data_i[2]; data_err_o = 1'b1; end
            SYN_D1: begin fixed_o[1] = ~data_i[1]; data_err_o = 1'b1; end
            SYN_D0: begin fixed_o[0] = ~data_i[0]; data_err_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: while the counter is held, periodically re-checks the
// live value against stored parity, returns a corrected word and logs errors.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SCRUB_INTERVAL = 16,
    parameter int ERR_CNT_W      = 8,
    localparam int BLOCKS        = WIDTH / 4,
    localparam int PARITY_BITS   = BLOCKS * 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       counter,
    input  logic [PARITY_BITS-1:0] parity_stored,
    ecc_scrub_ctrl_if.master       corr_if,
    output logic                   scrub_busy,
    output logic [PARITY_BITS-1:0] err_syndrome,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   err_sticky
);

    // Interval counter only has to hold SCRUB_INTERVAL-1.
    localparam int               CNT_W    = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCRUB_INTERVAL - 1);

    scrub_state_t                state_q, state_d;
    logic                        enable_dly_q;
    logic                        busy_q;
    logic                        corr_valid_q;
    logic [WIDTH-1:0]            corr_data_q;
    logic [CNT_W-1:0]            ivl_cnt_q;
    logic [PARITY_BITS-1:0]      err_syn_q;
    logic [ERR_CNT_W-1:0]        err_cnt_q;
    logic                        err_sticky_q;

    logic [BLOCKS-1:0][2:0]      syn_w;
    logic [BLOCKS-1:0][3:0]      fixed_w;
    logic [BLOCKS-1:0]           derr_w;
    logic                        syn_nz;
    logic                        any_derr;
    logic                        enable_fall;

    // Per-block syndrome and repair; blocks are independent.
    for (genvar b = 0; b < BLOCKS; b++) begin : g_blk
        assign syn_w[b] = hamming_syndrome(parity_stored[b*3 +: 3], counter[b*4 +: 4]);

        ecc_block_fix u_fix (
            .syn_i      (syn_w[b]),
            .data_i     (counter[b*4 +: 4]),
            .fixed_o    (fixed_w[b]),
            .data_err_o (derr_w[b])
        );
    end

    assign syn_nz      = |syn_w;
    assign any_derr    = |derr_w;
    assign enable_fall = enable_dly_q && !enable;

    // Next-state logic; enable high pulls every active state back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_fall) state_d = ARM;
            ARM:     state_d = CHECK;
            CHECK:   state_d = any_derr ? CORRECT : WAIT;
            CORRECT: if (corr_valid_q && corr_if.corr_ready) state_d = WAIT;
            WAIT:    if (ivl_cnt_q == '0) state_d = CHECK;
            default: state_d = IDLE;
        endcase
        if (enable && (state_q != IDLE)) state_d = IDLE;
    end

    // State register plus outputs that are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            enable_dly_q <= 1'b0;
            busy_q       <= 1'b0;
            corr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_dly_q <= enable;
            busy_q       <= (state_d != IDLE);
            corr_valid_q <= (state_d == CORRECT);
        end
    end

    // Corrected word is captured in CHECK and held untouched through CORRECT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_data_q <= '0;
        end else if (state_q == CHECK) begin
            corr_data_q <= fixed_w;
        end
    end

    // Interval counter: loaded on WAIT entry, counts down to the next CHECK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ivl_cnt_q <= '0;
        end else if ((state_d == WAIT) && (state_q != WAIT)) begin
            ivl_cnt_q <= CNT_LOAD;
        end else if ((state_q == WAIT) && (ivl_cnt_q != '0)) begin
            ivl_cnt_q <= ivl_cnt_q - 1'b1;
        end
    end

    // Error log: any nonzero CHECK is logged even if the scrub is being aborted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_syn_q    <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if ((state_q == CHECK) && syn_nz) begin
            err_syn_q    <= syn_w;
            err_sticky_q <= 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign corr_if.corr_valid = corr_valid_q;
    assign corr_if.corr_data  = corr_data_q;
    assign scrub_busy         = busy_q;
    assign err_syndrome       = err_syn_q;
    assign err_count          = err_cnt_q;
    assign err_sticky         = err_sticky_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: two instances share stimulus, the second
// with a 2-bit error counter for saturation.
module tb_ecc_scrub_ctrl;
    import ecc_scrub_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] counter;
    logic [2:0] parity;
    logic       ready;

    logic       busy0, sticky0;
    logic [2:0] esyn0;
    logic [7:0] cnt0;
    logic       busy1, sticky1;
    logic [2:0] esyn1;
    logic [1:0] cnt1;

    int n_checks;
    int n_fail;

    ecc_scrub_ctrl_if #(.WIDTH(4)) bus0 ();
    ecc_scrub_ctrl_if #(.WIDTH(4)) bus1 ();
    assign bus0.corr_ready = ready;
    assign bus1.corr_ready = ready;

    ecc_scrub_ctrl #(.WIDTH(4), .SCRUB_INTERVAL(16), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .counter(counter),
        .parity_stored(parity), .corr_if(bus0.master), .scrub_busy(busy0),
        .err_syndrome(esyn0), .err_count(cnt0), .err_sticky(sticky0)
    );

    ecc_scrub_ctrl #(.WIDTH(4), .SCRUB_INTERVAL(16), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .counter(counter),
        .parity_stored(parity), .corr_if(bus1.master), .scrub_busy(busy1),
        .err_syndrome(esyn1), .err_count(cnt1), .err_sticky(sticky1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Abort whatever is running, load new data, then drop enable.
    // Returns at the negedge where enable goes low (next posedge enters ARM).
    task automatic arm(input logic [3:0] c, input logic [2:0] p);
        @(negedge clk);
        enable  = 1'b1;
        counter = c;
        parity  = p;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b0; counter = 4'h0; parity = 3'h0; ready = 1'b0;
        #23;
        n_checks++; if (bus0.corr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus0.corr_valid); end
        n_checks++; if (bus0.corr_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus0.corr_data); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
        n_checks++; if (cnt0 !== 8'd0 || sticky0 !== 1'b0 || esyn0 !== 3'b000) begin n_fail++; $display("FAIL reset_log got cnt=%0d sticky=%b syn=%b want 0", cnt0, sticky0, esyn0); end
        n_checks++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt1 got %0d want 0", cnt1); end
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_hold;
        ready = 1'b1;
        arm(4'b0101, 3'b010);
        @(negedge clk);
        n_checks++; if (dut0.state_q !== ARM || busy0 !== 1'b1) begin n_fail++; $display("FAIL clean_arm got state=%0d busy=%b want ARM busy=1", dut0.state_q, busy0); end
        @(negedge clk);
        n_checks++; if (dut0.state_q !== CHECK) begin n_fail++; $display("FAIL clean_check got state=%0d want CHECK", dut0.state_q); end
        @(negedge clk);
        n_checks++; if (dut0.state_q !== WAIT) begin n_fail++; $display("FAIL clean_wait got state=%0d want WAIT", dut0.state_q); end
        for (int k = 0; k < 20; k++) begin
            n_checks++; if (bus0.corr_valid !== 1'b0) begin n_fail++; $display("FAIL clean_novalid cyc %0d got %b want 0", k, bus0.corr_valid); end
            @(negedge clk);
        end
        n_checks++; if (cnt0 !== 8'd0 || sticky0 !== 1'b0) begin n_fail++; $display("FAIL clean_log got cnt=%0d sticky=%b want 0/0", cnt0, sticky0); end
    endtask

    task automatic test_single_err;
        ready = 1'b1;
        arm(4'b1101, 3'b010);
        repeat (3) @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus0.corr_valid); end
        n_checks++; if (bus0.corr_data !== 4'b0101) begin n_fail++; $display("FAIL single_data got %b want 0101", bus0.corr_data); end
        n_checks++; if (cnt0 !== 8'd1 || sticky0 !== 1'b1) begin n_fail++; $display("FAIL single_log got cnt=%0d sticky=%b want 1/1", cnt0, sticky0); end
        n_checks++; if (esyn0 !== 3'b011) begin n_fail++; $display("FAIL single_syn got %b want 011", esyn0); end
        @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b0 || dut0.state_q !== WAIT) begin n_fail++; $display("FAIL single_done got valid=%b state=%0d want 0/WAIT", bus0.corr_valid, dut0.state_q); end
    endtask

    // Leaves the DUT freshly back in CORRECT (second check) for test_abort.
    task automatic test_backpressure;
        ready = 1'b0;
        arm(4'b1101, 3'b010);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (bus0.corr_valid !== 1'b1 || bus0.corr_data !== 4'b0101) begin n_fail++; $display("FAIL bp_hold cyc %0d got valid=%b data=%b want 1/0101", k, bus0.corr_valid, bus0.corr_data); end
            if (k == 5) ready = 1'b1;
        end
        n_checks++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL bp_cnt got %0d want 2", cnt0); end
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            n_checks++; if (bus0.corr_valid !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL bp_wait cyc %0d got valid=%b busy=%b want 0/1", k, bus0.corr_valid, busy0); end
        end
        @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b1 || cnt0 !== 8'd3) begin n_fail++; $display("FAIL bp_recheck got valid=%b cnt=%0d want 1/3", bus0.corr_valid, cnt0); end
    endtask

    task automatic test_abort;
        ready  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b0 || busy0 !== 1'b1 - 1'b1) begin n_fail++; $display("FAIL abort_out got valid=%b busy=%b want 0/0", bus0.corr_valid, busy0); end
        n_checks++; if (dut0.state_q !== IDLE || cnt0 !== 8'd3) begin n_fail++; $display("FAIL abort_state got state=%0d cnt=%0d want IDLE/3", dut0.state_q, cnt0); end
    endtask

    task automatic test_abort_with_ready;
        ready = 1'b0;
        arm(4'b1101, 3'b010);
        repeat (3) @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b1 || cnt0 !== 8'd4) begin n_fail++; $display("FAIL abrdy_pre got valid=%b cnt=%0d want 1/4", bus0.corr_valid, cnt0); end
        enable = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        n_checks++; if (bus0.corr_valid !== 1'b0 || busy0 !== 1'b0 || dut0.state_q !== IDLE) begin n_fail++; $display("FAIL abrdy_post got valid=%b busy=%b state=%0d want 0/0/IDLE", bus0.corr_valid, busy0, dut0.state_q); end
    endtask

    task automatic test_parity_only;
        ready = 1'b1;
        arm(4'b0101, 3'b011);
        repeat (3) @(negedge clk);
        n_checks++; if (dut0.state_q !== WAIT || bus0.corr_valid !== 1'b0) begin n_fail++; $display("FAIL par_state got state=%0d valid=%b want WAIT/0", dut0.state_q, bus0.corr_valid); end
        n_checks++; if (cnt0 !== 8'd5 || esyn0 !== 3'b001) begin n_fail++; $display("FAIL par_log got cnt=%0d syn=%b want 5/001", cnt0, esyn0); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus0.corr_valid !== 1'b0) begin n_fail++; $display("FAIL par_novalid cyc %0d got %b want 0", k, bus0.corr_valid); end
        end
    endtask

    task automatic test_saturation_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        arm(4'b0101, 3'b011);
        repeat (3) @(negedge clk);
        n_checks++; if (cnt1 !== 2'd1 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL sat_first got cnt1=%0d cnt0=%0d want 1/1", cnt1, cnt0); end
        repeat (34) @(negedge clk);
        n_checks++; if (cnt1 !== 2'd3) begin n_fail++; $display("FAIL sat_third got cnt1=%0d want 3", cnt1); end
        repeat (34) @(negedge clk);
        n_checks++; if (cnt1 !== 2'd3 || cnt0 !== 8'd5) begin n_fail++; $display("FAIL sat_fifth got cnt1=%0d cnt0=%0d want 3/5", cnt1, cnt0); end
        repeat (5) @(negedge clk);
        n_checks++; if (dut0.state_q !== WAIT || busy0 !== 1'b1) begin n_fail++; $display("FAIL sat_midwait got state=%0d busy=%b want WAIT/1", dut0.state_q, busy0); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b0 || bus0.corr_valid !== 1'b0 || bus0.corr_data !== 4'h0) begin n_fail++; $display("FAIL arst_out got busy=%b valid=%b data=%h want 0", busy0, bus0.corr_valid, bus0.corr_data); end
        n_checks++; if (cnt0 !== 8'd0 || sticky0 !== 1'b0 || esyn0 !== 3'b000) begin n_fail++; $display("FAIL arst_log0 got cnt=%0d sticky=%b syn=%b want 0", cnt0, sticky0, esyn0); end
        n_checks++; if (cnt1 !== 2'd0 || sticky1 !== 1'b0 || esyn1 !== 3'b000 || busy1 !== 1'b0) begin n_fail++; $display("FAIL arst_log1 got cnt=%0d sticky=%b syn=%b busy=%b want 0", cnt1, sticky1, esyn1, busy1); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (dut0.state_q !== IDLE || busy0 !== 1'b0) begin n_fail++; $display("FAIL arst_idle got state=%0d busy=%b want IDLE/0", dut0.state_q, busy0); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_hold();
        test_single_err();
        test_backpressure();
        test_abort();
        test_abort_with_ready();
        test_parity_only();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
